// File: rtl/video_stream_pkg.sv
// Shared definitions for the video stream blocks.
//   PIX_W / FB_ADDR_W : default pixel width and frame-buffer address width
//   DEF_WIDTH / DEF_HEIGHT : default frame geometry
//   rx_state_e : receiver framing state
//   pix_beat_t : one stream beat (start/end of packet + pixel)
package video_stream_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned FB_ADDR_W  = 19;
  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    SKIP
  } rx_state_e;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [PIX_W-1:0] data;
  } pix_beat_t;

endpackage

// File: rtl/video_stream_receiver_if.sv
// Stream-in and pixel-write handshake bundle for video_stream_receiver.
//   in_*  : Avalon-ST pixel stream (ready/valid/sop/eop/data)
//   wr_*  : pixel write request toward a frame buffer (valid/ready/addr/data)
//   slave : receiver view; master : view of the source/sink around it
interface video_stream_receiver_if #(
  parameter int unsigned DATA_W = video_stream_pkg::PIX_W,
  parameter int unsigned ADDR_W = video_stream_pkg::FB_ADDR_W
) ();

  logic              in_ready;
  logic              in_valid;
  logic              in_startofpacket;
  logic              in_endofpacket;
  logic [DATA_W-1:0] in_data;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    output in_ready,
    input  in_valid, in_startofpacket, in_endofpacket, in_data,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

  modport master (
    input  in_ready,
    output in_valid, in_startofpacket, in_endofpacket, in_data,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );

endinterface

// File: rtl/stream_skid_buffer.sv
// 2-entry skid buffer for a valid/ready stream.
//   clock, reset (async, active-low)
//   in_valid/in_ready/in_payload    : upstream side; in_ready is registered
//   out_valid/out_ready/out_payload : downstream side (head of buffer)
module stream_skid_buffer #(
  parameter int unsigned PAYLOAD_W = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic [PAYLOAD_W-1:0] entry [2];
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           count, count_next;
  logic                 ready_q;
  logic                 push, pop;

  assign push        = in_valid & ready_q;
  assign pop         = out_valid & out_ready;
  assign out_valid   = (count != 2'd0);
  assign out_payload = entry[rd_ptr];
  assign in_ready    = ready_q;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entry[0] <= '0;
      entry[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= in_payload;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count   <= count_next;
      // Ready is computed from the next occupancy so it is a flop output.
      ready_q <= (count_next < 2'd2);
    end
  end

endmodule

// File: rtl/video_stream_receiver.sv
// Avalon-ST video sink: turns framed pixel packets into row-major pixel
// writes (wr_addr = y*WIDTH+x), checks framing and counts good frames.
//   clock, reset        : system clock, async active-low reset
//   bus (slave)         : in_* stream input, wr_* pixel write output
//   frame_done          : pulse when the last pixel of a good frame is written
//   frame_count         : completed-frame counter (wraps)
//   err_short/err_long  : sticky framing errors, cleared by clear_errors
//   frame_checksum      : only with VIDEO_RX_CHECKSUM_EN; 16-bit pixel sum of
//                         the last completed frame
module video_stream_receiver
  import video_stream_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned DATA_W = PIX_W,
  parameter int unsigned ADDR_W = FB_ADDR_W
) (
  input  logic                    clock,
  input  logic                    reset,
  video_stream_receiver_if.slave  bus,
  output logic                    frame_done,
  output logic [15:0]             frame_count,
  output logic                    err_short,
  output logic                    err_long,
  input  logic                    clear_errors
`ifdef VIDEO_RX_CHECKSUM_EN
  ,output logic [15:0]            frame_checksum
`endif
);

  localparam int unsigned      TOTAL = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL - 1);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t             in_beat, head;
  logic              head_valid, head_pop, can_load;
  rx_state_e         state, state_next;
  logic [ADDR_W-1:0] idx, idx_next, idx_inc, load_addr;
  logic              load, load_last, sop_load, set_short, set_long;
  logic              wr_valid_q, wr_last_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign in_beat = '{sop: bus.in_startofpacket, eop: bus.in_endofpacket, data: bus.in_data};

  stream_skid_buffer #(.PAYLOAD_W($bits(beat_t))) u_skid (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (bus.in_valid),
    .in_ready    (bus.in_ready),
    .in_payload  (in_beat),
    .out_valid   (head_valid),
    .out_ready   (head_pop),
    .out_payload (head)
  );

  // The write register can take a new pixel when empty or retiring this cycle.
  assign can_load = ~wr_valid_q | bus.wr_ready;
  assign head_pop = head_valid & can_load;
  assign idx_inc  = idx + ADDR_W'(1);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    load_addr  = '0;
    load_last  = 1'b0;
    sop_load   = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    if (head_pop) begin
      if (head.sop) begin
        // SOP restarts a frame from any state.
        load     = 1'b1;
        sop_load = 1'b1;
        idx_next = '0;
        if (state == ACTIVE) set_short = 1'b1;
        if (head.eop) begin
          state_next = IDLE;
          if (TOTAL > 1) set_short = 1'b1;
          else           load_last = 1'b1;
        end else if (TOTAL == 1) begin
          set_long   = 1'b1;
          state_next = SKIP;
        end else begin
          state_next = ACTIVE;
        end
      end else begin
        case (state)
          ACTIVE: begin
            load      = 1'b1;
            load_addr = idx_inc;
            idx_next  = idx_inc;
            if (idx_inc == LAST) begin
              if (head.eop) begin
                load_last  = 1'b1;
                state_next = IDLE;
              end else begin
                set_long   = 1'b1;
                state_next = SKIP;
              end
            end else if (head.eop) begin
              set_short  = 1'b1;
              state_next = IDLE;
            end
          end
          SKIP:    if (head.eop) state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  assign frame_done   = wr_valid_q & wr_last_q & bus.wr_ready;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      wr_valid_q  <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_count <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (load) begin
        wr_valid_q <= 1'b1;
        wr_last_q  <= load_last;
        wr_addr_q  <= load_addr;
        wr_data_q  <= head.data;
      end else if (bus.wr_ready) begin
        wr_valid_q <= 1'b0;
        wr_last_q  <= 1'b0;
      end
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (clear_errors) begin
        err_short <= 1'b0;
        err_long  <= 1'b0;
      end else begin
        if (set_short) err_short <= 1'b1;
        if (set_long)  err_long  <= 1'b1;
      end
    end
  end

`ifdef VIDEO_RX_CHECKSUM_EN
  logic [15:0] cksum_acc;

  // On a same-cycle SOP load and frame_done, the latch sees the old frame sum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cksum_acc      <= '0;
      frame_checksum <= '0;
    end else begin
      if (load) cksum_acc <= (sop_load ? 16'd0 : cksum_acc) + 16'(head.data);
      if (frame_done) frame_checksum <= cksum_acc;
    end
  end
`endif

endmodule
